// File: rtl/uart_tx_unit.sv
// Bus-attached 8N1 UART transmitter with a small transmit FIFO and TXDATA/STATUS/CONTROL registers.
// Optional feature macro: UART_TX_IRQ_EN (enables the active-low "FIFO drained" interrupt).
module uart_tx_unit #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        AS_L,
    input  logic        WE_L,
    input  logic        UART_Select,
    input  logic [3:0]  Address,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        UART_Tx,
    output logic        IRQ_uart_L
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state_reg, state_next;
    logic [15:0]        baud_reg, baud_next;
    logic [2:0]         bit_reg, bit_next;
    logic [7:0]         shift_reg, shift_next;
    logic               tx_reg, tx_next;

    logic [7:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               overflow_reg;
    logic               tx_enable_reg;
    logic               irq_enable;

    logic               wr_prev_reg, rd_prev_reg;
    logic               access, wr_strobe, rd_strobe, wr_edge, rd_edge;
    logic               push_req, ctrl_wr, stat_rd;
    logic               push, pop, full, empty, start_ok, baud_done;
    logic [31:0]        status_word;
    logic               unused_bits;

    assign access    = UART_Select & ~AS_L;
    assign wr_strobe = access & ~WE_L;
    assign rd_strobe = access & WE_L;
    assign wr_edge   = wr_strobe & ~wr_prev_reg;
    assign rd_edge   = rd_strobe & ~rd_prev_reg;

    assign push_req  = wr_edge && (Address == 4'h0);
    assign ctrl_wr   = wr_edge && (Address == 4'h8);
    assign stat_rd   = rd_edge && (Address == 4'h4);

    assign empty     = (count_reg == '0);
    assign full      = (count_reg == CNT_W'(FIFO_DEPTH));
    // A pop in the same cycle frees a slot, so a write to a full FIFO can still land.
    assign push      = push_req && (!full || pop);
    assign start_ok  = !empty && tx_enable_reg;
    assign baud_done = (baud_reg == 16'd0);

    assign unused_bits = ^{data_in[31:8], data_in[1]};

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wr_prev_reg <= 1'b0;
            rd_prev_reg <= 1'b0;
        end else begin
            wr_prev_reg <= wr_strobe;
            rd_prev_reg <= rd_strobe;
        end
    end

    always_ff @(posedge Clock) begin
        if (push) begin
            mem[wr_ptr_reg] <= data_in[7:0];
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            tx_enable_reg <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
            if (push_req && !push) begin
                overflow_reg <= 1'b1;
            end else if (stat_rd) begin
                overflow_reg <= 1'b0;
            end
            if (ctrl_wr) begin
                tx_enable_reg <= data_in[0];
            end
        end
    end

`ifdef UART_TX_IRQ_EN
    logic irq_reg;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            irq_enable <= 1'b0;
            irq_reg    <= 1'b1;
        end else begin
            if (ctrl_wr) begin
                irq_enable <= data_in[1];
            end
            irq_reg <= ~(irq_enable && empty && (state_reg == IDLE));
        end
    end

    assign IRQ_uart_L = irq_reg;
`else
    assign irq_enable = 1'b0;
    assign IRQ_uart_L = 1'b1;
`endif

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_reg <= IDLE;
            baud_reg  <= 16'd0;
            bit_reg   <= 3'd0;
            shift_reg <= 8'd0;
            tx_reg    <= 1'b1;
        end else begin
            state_reg <= state_next;
            baud_reg  <= baud_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            tx_reg    <= tx_next;
        end
    end

    // tx_next always matches the level of the state being entered, so the line is a clean flop output.
    always_comb begin
        state_next = state_reg;
        baud_next  = baud_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        tx_next    = tx_reg;
        pop        = 1'b0;
        case (state_reg)
            IDLE: begin
                tx_next = 1'b1;
                if (start_ok) begin
                    pop        = 1'b1;
                    shift_next = mem[rd_ptr_reg];
                    state_next = START;
                    baud_next  = BAUD_MAX;
                    tx_next    = 1'b0;
                end
            end
            START: begin
                if (baud_done) begin
                    state_next = DATA;
                    baud_next  = BAUD_MAX;
                    bit_next   = 3'd0;
                    tx_next    = shift_reg[0];
                end else begin
                    baud_next = baud_reg - 16'd1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_next = BAUD_MAX;
                    if (bit_reg == 3'd7) begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end else begin
                        bit_next   = bit_reg + 3'd1;
                        shift_next = shift_reg >> 1;
                        tx_next    = shift_reg[1];
                    end
                end else begin
                    baud_next = baud_reg - 16'd1;
                end
            end
            STOP: begin
                if (baud_done) begin
                    if (start_ok) begin
                        pop        = 1'b1;
                        shift_next = mem[rd_ptr_reg];
                        state_next = START;
                        baud_next  = BAUD_MAX;
                        tx_next    = 1'b0;
                    end else begin
                        state_next = IDLE;
                        tx_next    = 1'b1;
                    end
                end else begin
                    baud_next = baud_reg - 16'd1;
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

    assign UART_Tx = tx_reg;

    always_comb begin
        status_word       = '0;
        status_word[0]    = (state_reg != IDLE);
        status_word[1]    = full;
        status_word[2]    = empty;
        status_word[3]    = overflow_reg;
        status_word[14:8] = 7'(count_reg);
    end

    always_comb begin
        data_out = '0;
        if (rd_strobe) begin
            case (Address)
                4'h4:    data_out = status_word;
                4'h8:    data_out = {30'd0, irq_enable, tx_enable_reg};
                default: data_out = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_unit.sv
// Directed/randomized bench for uart_tx_unit; expected serial frames come from a byte-queue model.
module tb_uart_tx_unit;

    localparam int CPB   = 4;
    localparam int DEPTH = 8;
    localparam int FRAME = 10 * CPB;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        AS_L, WE_L, UART_Select;
    logic [3:0]  Address;
    logic [31:0] data_in, data_out;
    logic        UART_Tx, IRQ_uart_L;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    logic [7:0] model_q[$];
    logic       model_ovf = 1'b0;
    logic       tx_log[$];
    logic       busy_log[$];
    logic       irq_log[$];

    uart_tx_unit #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .Clock(Clock), .Reset(Reset), .AS_L(AS_L), .WE_L(WE_L),
        .UART_Select(UART_Select), .Address(Address), .data_in(data_in),
        .data_out(data_out), .UART_Tx(UART_Tx), .IRQ_uart_L(IRQ_uart_L)
    );

    always #5 Clock = ~Clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic bus_idle();
        UART_Select = 1'b0; AS_L = 1'b1; WE_L = 1'b1; Address = 4'h0; data_in = '0;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input int hold);
        @(negedge Clock);
        UART_Select = 1'b1; AS_L = 1'b0; WE_L = 1'b0; Address = a; data_in = d;
        repeat (hold) @(negedge Clock);
        bus_idle();
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge Clock);
        UART_Select = 1'b1; AS_L = 1'b0; WE_L = 1'b1; Address = a;
        #1 d = data_out;
        @(negedge Clock);
        bus_idle();
    endtask

    task automatic model_push(input logic [7:0] b);
        if (model_q.size() < DEPTH) model_q.push_back(b);
        else model_ovf = 1'b1;
    endtask

    function automatic logic [31:0] model_status(input logic busy);
        logic [31:0] w;
        int n;
        n = model_q.size();
        w = '0;
        w[0] = busy;
        w[1] = (n == DEPTH);
        w[2] = (n == 0);
        w[3] = model_ovf;
        w[14:8] = 7'(n);
        return w;
    endfunction

    // Holds a STATUS read on the bus and logs the line, busy and irq once per cycle.
    task automatic capture(input int n);
        tx_log.delete(); busy_log.delete(); irq_log.delete();
        UART_Select = 1'b1; AS_L = 1'b0; WE_L = 1'b1; Address = 4'h4;
        for (int i = 0; i < n; i++) begin
            #1;
            tx_log.push_back(UART_Tx);
            busy_log.push_back(data_out[0]);
            irq_log.push_back(IRQ_uart_L);
            @(negedge Clock);
        end
        bus_idle();
    endtask

    function automatic int find_start(input int from);
        for (int i = from; i < tx_log.size(); i++) begin
            if (tx_log[i] === 1'b0) return i;
        end
        return -1;
    endfunction

    task automatic check_frames(input string tag, input int nframes);
        int cur;
        int s;
        int prev_end;
        int zeros;
        logic [63:0] obs_w, exp_w;
        logic [9:0]  bits10;
        logic [7:0]  b;
        cur = 0;
        prev_end = 0;
        for (int f = 0; f < nframes; f++) begin
            s = find_start(cur);
            check($sformatf("%s_found%0d", tag, f), 64'(s >= 0), 64'd1);
            if (s < 0) return;
            if (f == 0) check($sformatf("%s_latency_ok", tag), 64'(s <= 2), 64'd1);
            else        check($sformatf("%s_gap_ok%0d", tag, f), 64'((s - prev_end) <= 1), 64'd1);
            b = model_q.pop_front();
            bits10 = {1'b1, b, 1'b0};
            obs_w = '0;
            exp_w = '0;
            for (int k = 0; k < FRAME; k++) begin
                obs_w[k] = (s + k < tx_log.size()) ? tx_log[s + k] : 1'bx;
                exp_w[k] = bits10[k / CPB];
            end
            check($sformatf("%s_frame%0d_byte%02h", tag, f, b), obs_w, exp_w);
            prev_end = s + FRAME;
            cur = prev_end;
        end
        zeros = 0;
        for (int i = cur; i < tx_log.size(); i++) if (tx_log[i] !== 1'b1) zeros++;
        check($sformatf("%s_idle_after", tag), 64'(zeros), 64'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic [7:0]  b;
        int          busy_cnt;
        int          irq_low;
        int          ws;

        bus_idle();
        Reset = 1'b1;
        repeat (3) @(negedge Clock);
        Reset = 1'b0;

        // Reset state
        #1 check("reset_tx", 64'(UART_Tx), 64'd1);
        check("reset_irq", 64'(IRQ_uart_L), 64'd1);
        check("idle_data_out", 64'(data_out), 64'd0);
        bus_read(4'h4, rd); check("reset_status", 64'(rd), 64'(model_status(1'b0)));
        bus_read(4'h8, rd); check("reset_control", 64'(rd), 64'h1);
        bus_read(4'hC, rd); check("read_unmapped", 64'(rd), 64'h0);
        bus_read(4'h0, rd); check("read_txdata", 64'(rd), 64'h0);

        // Single frames: 0xA5 then random bytes
        for (int t = 0; t < 4; t++) begin
            b = (t == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
            bus_write(4'h0, {24'd0, b}, 1);
            model_push(b);
            capture(50);
            busy_cnt = 0;
            irq_low = 0;
            foreach (busy_log[i]) if (busy_log[i] === 1'b1) busy_cnt++;
            foreach (irq_log[i]) if (irq_log[i] !== 1'b1) irq_low++;
            check($sformatf("single%0d_busy_cycles", t), 64'(busy_cnt), 64'(FRAME));
            check($sformatf("single%0d_irq_high", t), 64'(irq_low), 64'd0);
            check_frames($sformatf("single%0d", t), 1);
        end

        // Overflow: nine writes into a disabled transmitter
        bus_write(4'h8, 32'h0, 1);
        for (int i = 0; i < DEPTH + 1; i++) begin
            b = 8'($urandom_range(0, 255));
            bus_write(4'h0, {24'd0, b}, 1);
            model_push(b);
        end
        bus_read(4'h4, rd); check("ovf_status", 64'(rd), 64'(model_status(1'b0)));
        model_ovf = 1'b0;
        bus_read(4'h4, rd); check("ovf_cleared", 64'(rd), 64'(model_status(1'b0)));
        bus_write(4'h8, 32'h1, 1);
        capture(DEPTH * FRAME + 20);
        check_frames("ovf_drain", DEPTH);
        bus_read(4'h4, rd); check("ovf_drained_status", 64'(rd), 64'(model_status(1'b0)));

        // Back-to-back frames
        bus_write(4'h8, 32'h0, 1);
        for (int i = 0; i < 5; i++) begin
            b = (i == 0) ? 8'h00 : (i == 1) ? 8'hFF : 8'($urandom_range(0, 255));
            bus_write(4'h0, {24'd0, b}, 1);
            model_push(b);
        end
        bus_read(4'h4, rd); check("b2b_loaded", 64'(rd), 64'(model_status(1'b0)));
        bus_write(4'h8, 32'h1, 1);
        capture(5 * (FRAME + 1) + 20);
        check_frames("b2b", 5);
        bus_read(4'h4, rd); check("b2b_empty", 64'(rd), 64'(model_status(1'b0)));

        // Held write strobe: five cycles low yields a single push
        bus_write(4'h8, 32'h0, 1);
        b = 8'($urandom_range(0, 255)) & 8'hF7;
        bus_write(4'h0, {24'd0, b}, 5);
        model_push(b);
        bus_read(4'h4, rd); check("held_strobe_status", 64'(rd), 64'(model_status(1'b0)));

        // Reset during data bit 3 (bit 3 forced to 0 so the line is low beforehand)
        bus_write(4'h8, 32'h1, 1);
        ws = -1;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (UART_Tx === 1'b0) begin ws = i; break; end
            @(negedge Clock);
        end
        check("rst_frame_started", 64'(ws >= 0), 64'd1);
        repeat (4 * CPB + 1) @(negedge Clock);
        check("rst_pre_bit3", 64'(UART_Tx), 64'd0);
        #2 Reset = 1'b1;
        #1 check("rst_tx_async", 64'(UART_Tx), 64'd1);
        @(negedge Clock);
        Reset = 1'b0;
        model_q.delete();
        model_ovf = 1'b0;
        bus_read(4'h4, rd); check("rst_status", 64'(rd), 64'h4);
        bus_read(4'h8, rd); check("rst_control", 64'(rd), 64'h1);

`ifdef UART_TX_IRQ_EN
        bus_write(4'h8, 32'h3, 1);
        repeat (2) @(negedge Clock);
        #1 check("irq_idle_low", 64'(IRQ_uart_L), 64'd0);
        bus_read(4'h8, rd); check("irq_control", 64'(rd), 64'h3);
        b = 8'($urandom_range(0, 255));
        bus_write(4'h0, {24'd0, b}, 1);
        model_push(b);
        capture(50);
        ws = find_start(0);
        check("irq_mid_frame_high", 64'((ws >= 0) ? irq_log[ws + FRAME / 2] : 1'bx), 64'd1);
        check("irq_after_low", 64'(irq_log[irq_log.size() - 1]), 64'd0);
        check_frames("irq", 1);
`else
        bus_write(4'h8, 32'h3, 1);
        bus_read(4'h8, rd); check("control_irq_bit_ignored", 64'(rd), 64'h1);
        repeat (2) @(negedge Clock);
        #1 check("irq_tied_high", 64'(IRQ_uart_L), 64'd1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
